// File: rtl/alu_logic_seq8_pkg.sv
// Shared definitions for the 8-bit boolean logic sequencer: opcodes, FSM
// state encodings and the latched-operand bundle.
package alu_logic_seq8_pkg;

  localparam logic [3:0] OP_AND = 4'b0101;
  localparam logic [3:0] OP_OR  = 4'b0110;
  localparam logic [3:0] OP_XOR = 4'b0111;
  localparam logic [3:0] OP_NOT = 4'b1000;

  localparam logic [1:0] ST_IDLE = 2'b00;
  localparam logic [1:0] ST_EXEC = 2'b01;
  localparam logic [1:0] ST_HOLD = 2'b10;

  typedef struct packed {
    logic [3:0] opcode;
    logic [7:0] a;
    logic [7:0] b;
  } operands_t;

  function automatic logic is_logic_op(input logic [3:0] op);
    return (op == OP_AND) || (op == OP_OR) || (op == OP_XOR) || (op == OP_NOT);
  endfunction

endpackage

// File: rtl/alu_logic_seq8_boolean8.sv
// boolean8: purely combinational 8-bit logic function selected by opcode.
// Unknown opcodes produce zero; legality is judged by the caller.
module boolean8
  import alu_logic_seq8_pkg::*;
(
  input  logic [3:0] opcode,
  input  logic [7:0] a,
  input  logic [7:0] b,
  output logic [7:0] y
);

  always_comb begin
    y = 8'h00;
    case (opcode)
      OP_AND:  y = a & b;
      OP_OR:   y = a | b;
      OP_XOR:  y = a ^ b;
      OP_NOT:  y = ~a;
      default: y = 8'h00;
    endcase
  end

endmodule

// File: rtl/alu_logic_seq8.sv
// alu_logic_seq8: accepts one logic instruction per handshake, runs it through
// boolean8, and holds the result with flags until downstream takes it.
module alu_logic_seq8
  import alu_logic_seq8_pkg::*;
#(
  parameter logic [7:0] ACC_INIT = 8'h00,
  parameter int         CNT_W    = 16
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [3:0]       in_opcode,
  input  logic [7:0]       in_a,
  input  logic [7:0]       in_b,
  input  logic             in_use_acc,
  input  logic             clr_acc,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [7:0]       out_res,
  output logic             out_zero,
  output logic             out_neg,
  output logic             out_illegal,
  output logic [7:0]       acc,
  output logic [CNT_W-1:0] op_count
);

  logic [1:0]       state_q,   state_d;
  operands_t        ops_q,     ops_d;
  logic [7:0]       res_q,     res_d;
  logic             zero_q,    zero_d;
  logic             neg_q,     neg_d;
  logic             illegal_q, illegal_d;
  logic [7:0]       acc_q,     acc_d;
  logic [CNT_W-1:0] cnt_q,     cnt_d;

  logic [7:0] bool_y;
  logic       op_legal;

  boolean8 u_boolean8 (
    .opcode (ops_q.opcode),
    .a      (ops_q.a),
    .b      (ops_q.b),
    .y      (bool_y)
  );

  assign op_legal = is_logic_op(ops_q.opcode);

  always_comb begin
    state_d   = state_q;
    ops_d     = ops_q;
    res_d     = res_q;
    zero_d    = zero_q;
    neg_d     = neg_q;
    illegal_d = illegal_q;
    acc_d     = acc_q;
    cnt_d     = cnt_q;

    case (state_q)
      ST_IDLE: begin
        // Operand A samples acc_q, so a same-edge clear still feeds the old value.
        if (in_valid) begin
          ops_d.opcode = in_opcode;
          ops_d.a      = in_use_acc ? acc_q : in_a;
          ops_d.b      = in_b;
          state_d      = ST_EXEC;
        end
        if (clr_acc) begin
          acc_d = ACC_INIT;
        end
      end

      ST_EXEC: begin
        state_d = ST_HOLD;
        if (op_legal) begin
          res_d     = bool_y;
          zero_d    = (bool_y == 8'h00);
          neg_d     = bool_y[7];
          illegal_d = 1'b0;
          acc_d     = bool_y;
        end else begin
          res_d     = 8'h00;
          zero_d    = 1'b1;
          neg_d     = 1'b0;
          illegal_d = 1'b1;
        end
      end

      ST_HOLD: begin
        if (clr_acc) begin
          acc_d = ACC_INIT;
        end
        if (out_ready) begin
          state_d = ST_IDLE;
          cnt_d   = cnt_q + CNT_W'(1);
        end
      end

      default: state_d = ST_IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q   <= ST_IDLE;
      ops_q     <= '0;
      res_q     <= 8'h00;
      zero_q    <= 1'b0;
      neg_q     <= 1'b0;
      illegal_q <= 1'b0;
      acc_q     <= ACC_INIT;
      cnt_q     <= '0;
    end else begin
      state_q   <= state_d;
      ops_q     <= ops_d;
      res_q     <= res_d;
      zero_q    <= zero_d;
      neg_q     <= neg_d;
      illegal_q <= illegal_d;
      acc_q     <= acc_d;
      cnt_q     <= cnt_d;
    end
  end

  assign in_ready    = (state_q == ST_IDLE);
  assign out_valid   = (state_q == ST_HOLD);
  assign out_res     = res_q;
  assign out_zero    = zero_q;
  assign out_neg     = neg_q;
  assign out_illegal = illegal_q;
  assign acc         = acc_q;
  assign op_count    = cnt_q;

endmodule
